// File: rtl/data_memory_responder.sv
// data_memory_responder: multi-cycle data memory with stall/ack handshake for a pipeline MEM stage
// Parameters: LATENCY (1..15) edges from capture to completion; DEPTH_LOG2 log2 of 32-bit word count.
// Ports: clk_i clock; rst_i async active-high reset; MemRead_i/MemWrite_i requests (both high = write);
//   Address_i byte address; Writedata_i store data; Readdata_o registered load data;
//   stall_o freeze request; ack_o one-cycle completion; err_o misalignment pulse with ack_o.
// Macro DMEM_MISALIGN_CHK_EN enables word-alignment checking (err_o tied 0 otherwise).
module data_memory_responder #(
  parameter int LATENCY    = 3,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Writedata_i,
  output logic [31:0] Readdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q;
  logic wr_q;
  logic [DEPTH_LOG2-1:0] idx_q, cur_idx;
  logic [31:0] wdata_q, cur_wdata;
  logic req, cap, enter_done, cur_wr, cur_mis;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic unused_addr;
  assign unused_addr = ^Address_i;
  assign req = MemRead_i | MemWrite_i;
  assign cap = state_q == IDLE && req;
`ifdef DMEM_MISALIGN_CHK_EN
  logic mis_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) mis_q <= 1'b0;
    else if (cap) mis_q <= |Address_i[1:0];
  assign cur_mis = (state_q == IDLE) ? |Address_i[1:0] : mis_q;
  assign err_o = state_q == DONE && mis_q;
`else
  assign cur_mis = 1'b0;
  assign err_o = 1'b0;
`endif
  // With LATENCY=1 the capture edge is also the completion edge, so the live inputs are used then.
  assign cur_wr    = (state_q == IDLE) ? MemWrite_i : wr_q;
  assign cur_idx   = (state_q == IDLE) ? Address_i[DEPTH_LOG2+1:2] : idx_q;
  assign cur_wdata = (state_q == IDLE) ? Writedata_i : wdata_q;
  assign enter_done = state_d == DONE && state_q != DONE;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // BUSY leaves when the counter decrements to zero on this edge.
  always_comb begin
    state_d = state_q == IDLE ? (req ? (LATENCY == 1 ? DONE : BUSY) : IDLE)
            : state_q == BUSY ? (cnt_q <= 4'd1 ? DONE : BUSY)
            : IDLE;
  end
  always_comb begin
    stall_o = !rst_i && (cap || state_q == BUSY);
    ack_o   = state_q == DONE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      Readdata_o <= '0;
    end else begin
      if (cap) begin
        cnt_q   <= 4'(LATENCY - 1);
        wr_q    <= MemWrite_i;
        idx_q   <= Address_i[DEPTH_LOG2+1:2];
        wdata_q <= Writedata_i;
      end else if (state_q == BUSY) cnt_q <= cnt_q - 4'd1;
      if (enter_done && !cur_wr && !cur_mis) Readdata_o <= mem[cur_idx];
    end
  // Memory has no reset; the rst_i gate keeps a write aborted by reset from committing.
  always_ff @(posedge clk_i)
    if (enter_done && !rst_i && cur_wr && !cur_mis) mem[cur_idx] <= cur_wdata;
endmodule
